// File: rtl/axi_timer_slave.sv
// AXI4 slave exposing a RISC-V style machine timer: 64-bit mtime and mtimecmp,
// with independent read/write channel FSMs and a registered timer interrupt.
module axi_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        awvalid,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [3:0]  awcache,
    input  logic        awprot,
    input  logic        awqos,
    input  logic        awregion,
    output logic        awready,

    input  logic        wvalid,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    output logic        wready,

    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,

    input  logic        arvalid,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [3:0]  arcache,
    input  logic        arprot,
    input  logic        arqos,
    input  logic        arregion,
    output logic        arready,

    output logic [3:0]  rid,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,

    output logic        timer_irq
);

    localparam logic [15:0] PRESC_MAX   = 16'(TICK_DIV - 1);
    localparam logic [28:0] CMP_IDX     = 29'h0000_0800;
    localparam logic [28:0] TIME_IDX    = 29'h0000_17FF;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t    w_state;
    logic [3:0]  wr_id;
    logic [31:0] wr_addr;
    logic [1:0]  wr_burst;
    logic        wr_err;
    logic [31:0] wr_off;
    logic        wr_hit_cmp;
    logic        wr_hit_time;
    logic        wr_hit;
    logic        w_fire;

    r_state_t    r_state;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic [1:0]  rd_burst;
    logic [7:0]  rd_cnt;
    logic [31:0] rd_next_addr;
    logic [31:0] rd_off;
    logic        rd_hit_cmp;
    logic        rd_hit_time;
    logic [63:0] rd_next_data;
    logic        rd_next_err;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] presc;
    logic        tick;

    logic        unused_ok;
    assign unused_ok = ^{awlen, awsize, awcache, awprot, awqos, awregion,
                         arsize, arcache, arprot, arqos, arregion,
                         wr_off[2:0], rd_off[2:0]};

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_hit_cmp  = (wr_off[31:3] == CMP_IDX);
    assign wr_hit_time = (wr_off[31:3] == TIME_IDX);
    assign wr_hit      = wr_hit_cmp || wr_hit_time;
    assign w_fire      = (w_state == W_DATA) && wvalid && wready;

    // Address of the beat about to be captured: the new AR address when idle,
    // otherwise the following beat of the current burst.
    always_comb begin
        rd_next_addr = araddr;
        if (r_state == R_DATA) begin
            rd_next_addr = (rd_burst == BURST_FIXED) ? rd_addr : rd_addr + 32'd8;
        end
    end

    assign rd_off      = rd_next_addr - BASE_ADDR;
    assign rd_hit_cmp  = (rd_off[31:3] == CMP_IDX);
    assign rd_hit_time = (rd_off[31:3] == TIME_IDX);
    assign rd_next_err = !(rd_hit_cmp || rd_hit_time);

    always_comb begin
        rd_next_data = 64'd0;
        if (rd_hit_cmp)       rd_next_data = mtimecmp;
        else if (rd_hit_time) rd_next_data = mtime;
    end

    assign tick = (presc == PRESC_MAX);

    // Write channel: one AW, then W beats until wlast, then a single B response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= 4'd0;
            bresp    <= RESP_OKAY;
            wr_id    <= 4'd0;
            wr_addr  <= 32'd0;
            wr_burst <= 2'b00;
            wr_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        wr_id    <= awid;
                        wr_addr  <= awaddr;
                        wr_burst <= awburst;
                        wr_err   <= 1'b0;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (!wr_hit) wr_err <= 1'b1;
                        if (wr_burst != BURST_FIXED) wr_addr <= wr_addr + 32'd8;
                        if (wlast) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= wr_id;
                            bresp   <= (wr_err || !wr_hit) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    awready <= 1'b0;
                    wready  <= 1'b0;
                    bvalid  <= 1'b0;
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel: each beat's value is captured when the beat starts so the
    // R payload holds steady under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rdata    <= 64'd0;
            rid      <= 4'd0;
            rresp    <= RESP_OKAY;
            rd_addr  <= 32'd0;
            rd_len   <= 8'd0;
            rd_burst <= 2'b00;
            rd_cnt   <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        rid      <= arid;
                        rd_addr  <= araddr;
                        rd_len   <= arlen;
                        rd_burst <= arburst;
                        rd_cnt   <= 8'd0;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rdata    <= rd_next_data;
                        rresp    <= rd_next_err ? RESP_SLVERR : RESP_OKAY;
                        rlast    <= (arlen == 8'd0);
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rd_addr <= rd_next_addr;
                            rd_cnt  <= rd_cnt + 8'd1;
                            rdata   <= rd_next_data;
                            rresp   <= rd_next_err ? RESP_SLVERR : RESP_OKAY;
                            rlast   <= ((rd_cnt + 8'd1) == rd_len);
                        end
                    end
                end
            endcase
        end
    end

    // A write beat to mtime replaces that cycle's increment entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc     <= 16'd0;
            timer_irq <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (w_fire && wr_hit_time) begin
                mtime <= merge_bytes(mtime, wdata, wstrb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (w_fire && wr_hit_cmp) begin
                mtimecmp <= merge_bytes(mtimecmp, wdata, wstrb);
            end
            timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_axi_timer_slave.sv
// Directed self-checking bench for axi_timer_slave (default parameters, TICK_DIV=1).
module tb_axi_timer_slave;

    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam logic [1:0]  FIXED = 2'b00;
    localparam logic [1:0]  INCR  = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid, awprot, awqos, awregion, awready;
    logic [3:0]  awid, awcache;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wlast, wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        arvalid, arprot, arqos, arregion, arready;
    logic [3:0]  arid, arcache;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        timer_irq;

    axi_timer_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .awregion(awregion), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .arregion(arregion), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Counts clock edges since reset release; with TICK_DIV=1 this predicts mtime.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] wb_data [4];
    logic [7:0]  wb_strb [4];
    int          wb_edge [4];
    int          aw_edge;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        w_timeout, w_early;

    logic [63:0] rb_data [4];
    logic [1:0]  rb_resp [4];
    logic        rb_last [4];
    logic [3:0]  rb_id   [4];
    int          ar_edge;
    logic        r_timeout, r_unstable;

    task automatic axi_write(input logic [31:0] addr, input logic [1:0] burst,
                             input logic [3:0] id, input int nbeats, input int pre_w);
        int guard;
        w_timeout = 1'b0;
        w_early   = 1'b0;
        if (pre_w > 0) begin
            wvalid = 1'b1; wdata = wb_data[0]; wstrb = wb_strb[0]; wlast = (nbeats == 1);
            repeat (pre_w) begin
                @(negedge clk);
                if (wready) w_early = 1'b1;
                @(posedge clk); #1;
            end
        end
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(nbeats - 1);
        awburst = burst; awsize = 3'd3;
        guard = 0;
        do begin
            @(negedge clk);
            if (wready) w_early = 1'b1;
            guard++;
        end while (!awready && guard < 20);
        if (!awready) w_timeout = 1'b1;
        aw_edge = cyc + 1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1'b1; wdata = wb_data[b]; wstrb = wb_strb[b]; wlast = (b == nbeats - 1);
            guard = 0;
            do begin @(negedge clk); guard++; end while (!wready && guard < 20);
            if (!wready) w_timeout = 1'b1;
            wb_edge[b] = cyc + 1;
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bvalid && guard < 20);
        if (!bvalid) w_timeout = 1'b1;
        b_id = bid; b_resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id, input bit toggle);
        int guard, beats;
        logic stalled, snap_l;
        logic [63:0] snap_d;
        logic [1:0] snap_r;
        r_timeout = 1'b0; r_unstable = 1'b0; stalled = 1'b0;
        snap_d = 64'd0; snap_r = 2'd0; snap_l = 1'b0;
        arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd3;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!arready && guard < 20);
        if (!arready) r_timeout = 1'b1;
        ar_edge = cyc + 1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = !toggle;
        beats = 0; guard = 0;
        while (beats <= int'(len) && guard < 100) begin
            @(negedge clk);
            guard++;
            if (rvalid) begin
                if (stalled && (rdata !== snap_d || rresp !== snap_r || rlast !== snap_l))
                    r_unstable = 1'b1;
                if (rready) begin
                    rb_data[beats] = rdata; rb_resp[beats] = rresp;
                    rb_last[beats] = rlast; rb_id[beats] = rid;
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    snap_d = rdata; snap_r = rresp; snap_l = rlast;
                end
            end
            @(posedge clk); #1;
            if (toggle) rready = !rready;
        end
        if (beats <= int'(len)) r_timeout = 1'b1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({awready, arready, bvalid, rvalid, rlast, timer_irq} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 000000",
                     {awready, arready, bvalid, rvalid, rlast, timer_irq});
        end
        tests_run++;
        if ({rdata, bid, rid, bresp, rresp} !== 76'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_payload: got %h, expected 0", {rdata, bid, rid, bresp, rresp});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({awready, arready} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL ready_after_reset: got %b, expected 11", {awready, arready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cmp_irq();
        int guard;
        wb_data[0] = 64'h0000_0000_0000_0010; wb_strb[0] = 8'hFF;
        axi_write(BASE + 32'h4000, INCR, 4'h5, 1, 0);
        tests_run++;
        if ({w_timeout, b_resp, b_id} !== {1'b0, 2'b00, 4'h5}) begin
            tests_failed++;
            $display("[TB] FAIL cmp_write_resp: got to=%b resp=%b id=%h, expected to=0 resp=00 id=5",
                     w_timeout, b_resp, b_id);
        end
        tests_run++;
        if (timer_irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_early: got %b, expected 0", timer_irq);
        end
        guard = 0;
        do begin @(negedge clk); guard++; end while (!timer_irq && guard < 60);
        tests_run++;
        if (cyc !== 17) begin
            tests_failed++;
            $display("[TB] FAIL irq_rise_cycle: got %0d, expected 17", cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_burst();
        logic [63:0] exp_d [4];
        logic [1:0]  exp_r [4];
        logic        exp_l [4];
        exp_d = '{64'd0, 64'd0, 64'h10, 64'd0};
        exp_r = '{2'b10, 2'b10, 2'b00, 2'b10};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        axi_read(BASE + 32'h3FF0, 8'd3, INCR, 4'h9, 1'b1);
        tests_run++;
        if ({r_timeout, r_unstable} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL burst_stability: got to=%b unstable=%b, expected 0 0", r_timeout, r_unstable);
        end
        for (int b = 0; b < 4; b++) begin
            tests_run++;
            if ({rb_data[b], rb_resp[b], rb_last[b], rb_id[b]} !== {exp_d[b], exp_r[b], exp_l[b], 4'h9}) begin
                tests_failed++;
                $display("[TB] FAIL burst_beat%0d: got data=%h resp=%b last=%b id=%h, expected data=%h resp=%b last=%b id=9",
                         b, rb_data[b], rb_resp[b], rb_last[b], rb_id[b], exp_d[b], exp_r[b], exp_l[b]);
            end
        end
    endtask

    task automatic test_mtime_write();
        logic [63:0] before_byte, after_byte, expected;
        wb_data[0] = 64'h1122_3344_5566_7700; wb_strb[0] = 8'hFF;
        wb_data[1] = 64'hDEAD_BEEF_CAFE_F0AB; wb_strb[1] = 8'h01;
        axi_write(BASE + 32'hBFF8, FIXED, 4'h3, 2, 0);
        tests_run++;
        if ({w_timeout, b_resp, b_id} !== {1'b0, 2'b00, 4'h3}) begin
            tests_failed++;
            $display("[TB] FAIL mtime_write_resp: got to=%b resp=%b id=%h, expected to=0 resp=00 id=3",
                     w_timeout, b_resp, b_id);
        end
        before_byte = 64'h1122_3344_5566_7700 + 64'(wb_edge[1] - 1 - wb_edge[0]);
        after_byte  = {before_byte[63:8], 8'hAB};
        axi_read(BASE + 32'hBFF8, 8'd0, INCR, 4'h1, 1'b0);
        expected = after_byte + 64'(ar_edge - 1 - wb_edge[1]);
        tests_run++;
        if ({r_timeout, rb_data[0], rb_resp[0], rb_last[0]} !== {1'b0, expected, 2'b00, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL mtime_byte_write: got to=%b data=%h resp=%b last=%b, expected data=%h resp=00 last=1",
                     r_timeout, rb_data[0], rb_resp[0], rb_last[0], expected);
        end
    endtask

    task automatic test_w_before_aw();
        wb_data[0] = 64'h8000_0000_0000_0000; wb_strb[0] = 8'hFF;
        axi_write(BASE + 32'h4000, INCR, 4'hA, 1, 3);
        tests_run++;
        if ({w_timeout, w_early, b_resp, b_id} !== {1'b0, 1'b0, 2'b00, 4'hA}) begin
            tests_failed++;
            $display("[TB] FAIL early_w_resp: got to=%b early=%b resp=%b id=%h, expected to=0 early=0 resp=00 id=a",
                     w_timeout, w_early, b_resp, b_id);
        end
        tests_run++;
        if (wb_edge[0] !== aw_edge + 1) begin
            tests_failed++;
            $display("[TB] FAIL early_w_accept_edge: got %0d, expected %0d", wb_edge[0], aw_edge + 1);
        end
        axi_read(BASE + 32'h4000, 8'd0, INCR, 4'h2, 1'b0);
        tests_run++;
        if (rb_data[0] !== 64'h8000_0000_0000_0000) begin
            tests_failed++;
            $display("[TB] FAIL early_w_data: got %h, expected 8000000000000000", rb_data[0]);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (timer_irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_unsigned: got %b, expected 0", timer_irq);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unmapped_write();
        wb_data[0] = 64'h5555_5555_5555_5555; wb_strb[0] = 8'hFF;
        wb_data[1] = 64'h8000_0000_0000_0001; wb_strb[1] = 8'hFF;
        axi_write(BASE + 32'h3FF8, INCR, 4'h6, 2, 0);
        tests_run++;
        if ({w_timeout, b_resp, b_id} !== {1'b0, 2'b10, 4'h6}) begin
            tests_failed++;
            $display("[TB] FAIL unmapped_write_resp: got to=%b resp=%b id=%h, expected to=0 resp=10 id=6",
                     w_timeout, b_resp, b_id);
        end
        axi_read(BASE + 32'h4000, 8'd0, INCR, 4'h4, 1'b0);
        tests_run++;
        if ({rb_data[0], rb_resp[0], rb_id[0]} !== {64'h8000_0000_0000_0001, 2'b00, 4'h4}) begin
            tests_failed++;
            $display("[TB] FAIL incr_write_second_beat: got data=%h resp=%b id=%h, expected data=8000000000000001 resp=00 id=4",
                     rb_data[0], rb_resp[0], rb_id[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int guard;
        arvalid = 1'b1; araddr = BASE + 32'h4000; arlen = 8'd3; arburst = INCR; arid = 4'h2;
        rready = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!arready && guard < 20);
        @(posedge clk); #1;
        arvalid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!rvalid && guard < 20);
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({rvalid, rlast} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL beat1_present: got valid/last=%b, expected 10", {rvalid, rlast});
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rvalid, rlast, arready} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_read: got valid/last/arready=%b, expected 000", {rvalid, rlast, arready});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (arready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL arready_after_reset: got %b, expected 1", arready);
        end
        @(posedge clk); #1;
        axi_read(BASE + 32'hBFF8, 8'd0, INCR, 4'h4, 1'b0);
        tests_run++;
        if ({r_timeout, rb_data[0]} !== {1'b0, 64'(ar_edge - 1)}) begin
            tests_failed++;
            $display("[TB] FAIL mtime_after_reset: got to=%b data=%h, expected to=0 data=%h",
                     r_timeout, rb_data[0], 64'(ar_edge - 1));
        end
    endtask

    task automatic test_concurrent();
        wb_data[0] = 64'h0123_4567_89AB_CDEF; wb_strb[0] = 8'hFF;
        fork
            axi_write(BASE + 32'h4000, INCR, 4'h7, 1, 0);
            begin
                @(posedge clk); #1;
                axi_read(BASE + 32'h4000, 8'd0, INCR, 4'h8, 1'b0);
            end
        join
        tests_run++;
        if (ar_edge !== wb_edge[0]) begin
            tests_failed++;
            $display("[TB] FAIL concurrent_alignment: got ar edge %0d, expected %0d", ar_edge, wb_edge[0]);
        end
        tests_run++;
        if ({rb_data[0], rb_id[0], b_resp} !== {64'hFFFF_FFFF_FFFF_FFFF, 4'h8, 2'b00}) begin
            tests_failed++;
            $display("[TB] FAIL read_during_write: got data=%h id=%h bresp=%b, expected data=ffffffffffffffff id=8 bresp=00",
                     rb_data[0], rb_id[0], b_resp);
        end
        axi_read(BASE + 32'h4000, 8'd0, INCR, 4'h8, 1'b0);
        tests_run++;
        if (rb_data[0] !== 64'h0123_4567_89AB_CDEF) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_read: got %h, expected 0123456789abcdef", rb_data[0]);
        end
    endtask

    initial begin
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        awcache = 0; awprot = 0; awqos = 0; awregion = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        arcache = 0; arprot = 0; arqos = 0; arregion = 0; rready = 0;
        test_reset();
        test_cmp_irq();
        test_read_burst();
        test_mtime_write();
        test_w_before_aw();
        test_unmapped_write();
        test_reset_mid_read();
        test_concurrent();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_timer_slave.md
AXI_TIMER_SLAVE -- requirements
Module: axi_timer_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0200_0000, giving the slave base address.
REQ-003 The block SHALL have parameter TICK_DIV, default 1, giving the number of clk cycles per mtime increment (range 1..65535).
REQ-004 clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 AW channel, inputs: awvalid 1, awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awcache 4, awprot 1, awqos 1, awregion 1; output: awready 1.
REQ-006 W channel, inputs: wvalid 1, wdata 64, wstrb 8, wlast 1; output: wready 1.
REQ-007 B channel, outputs: bid 4, bresp 2, bvalid 1; input: bready 1.
REQ-008 AR channel, inputs: arvalid 1, arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arcache 4, arprot 1, arqos 1, arregion 1; output: arready 1.
REQ-009 R channel, outputs: rid 4, rdata 64, rresp 2, rlast 1, rvalid 1; input: rready 1.
REQ-010 timer_irq  out  1  machine timer interrupt, registered.
REQ-011 The block SHALL accept and ignore the cache, prot, qos, region and size inputs; all beats are 64-bit.

Function
REQ-012 Register map: offset 0x4000 SHALL be mtimecmp (64-bit, R/W); offset 0xBFF8 SHALL be mtime (64-bit, R/W); decode SHALL use addr[15:3] after subtracting BASE_ADDR; all other offsets are unmapped.
REQ-013 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-014 In W_IDLE, awvalid&awready SHALL latch awid, awaddr, awburst and go to W_DATA on the next cycle.
REQ-015 In W_DATA, each wvalid&wready beat SHALL update the addressed register byte-wise per wstrb; for INCR the beat address SHALL advance by 8; for FIXED it SHALL stay constant.
REQ-016 The beat with wlast=1 SHALL move the FSM to W_RESP; wlast alone ends the burst, and awlen is not checked.
REQ-017 In W_RESP, bid SHALL be the latched awid; bresp SHALL be 2'b10 (SLVERR) if any beat hit an unmapped offset, else 2'b00; bvalid&bready SHALL return the FSM to W_IDLE.
REQ-018 W beats presented before the AW handshake SHALL be held off (wready=0) and are not consumed.
REQ-019 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-020 R_IDLE arvalid&arready SHALL latch arid, araddr, arlen, arburst, clear the beat counter and go to R_DATA.
REQ-021 In R_DATA, rvalid=1 and rid=latched arid; rdata SHALL be the addressed register (0 if unmapped); rresp SHALL be 2'b00, or 2'b10 if unmapped; rlast=1 when beat counter == arlen.
REQ-022 rdata, rresp and rlast SHALL remain stable while rvalid=1 and rready=0; the register value SHALL be captured into a holding register at beat start.
REQ-023 rvalid&rready SHALL advance the address and counter; on the rlast beat the FSM SHALL return to R_IDLE.
REQ-024 The read and write FSMs SHALL operate concurrently and independently.
REQ-025 A read of a register written in the same cycle SHALL return the pre-write value.
REQ-026 A prescaler SHALL count 0..TICK_DIV-1; on wrap, mtime SHALL increment by 1 mod 2^64.
REQ-027 A write beat to mtime SHALL take priority over the increment in the same cycle: written bytes take the new data, unwritten bytes keep their old value, and there is no increment that cycle.
REQ-028 timer_irq SHALL be registered as (mtime >= mtimecmp), unsigned, one cycle after the values.

Reset
REQ-029 On rst_n low, both FSMs SHALL go asynchronously to their IDLE states, including mid-burst, and the in-flight transaction is dropped.
REQ-030 Reset values SHALL be: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, timer_irq=0, bvalid=0, rvalid=0, rlast=0, rdata=0, bid=0, rid=0, bresp=0, rresp=0.
REQ-031 In reset, awready and arready SHALL be 0; they SHALL become 1 in the first cycle after rst_n deasserts.

Verification
REQ-032 Write 64'h0000_0000_0000_0010 to BASE+0x4000 with strb 8'hFF, with mtime counting from 0 and TICK_DIV=1 -> bresp=00 and bid echoed; timer_irq rises one cycle after mtime reaches 0x10.
REQ-033 4-beat INCR read (arlen=3) from BASE+0x3FF0 with rready toggling -> beats 0 and 1 return rdata=0 with rresp=10; beat 2 returns mtimecmp with rresp=00; beat 3 returns 0 with rresp=10 and rlast=1; rdata is stable during stalls.
REQ-034 Write 8'hAB to mtime byte 0 only (wstrb=8'h01) in a tick cycle -> mtime[7:0]=8'hAB, upper bytes unchanged, no increment that cycle.
REQ-035 Drive wvalid 3 cycles before awvalid -> wready stays 0 until the cycle after the AW handshake; exactly one write occurs.
REQ-036 Assert rst_n low during R_DATA beat 1 of 4 -> rvalid=0 immediately; after release arready=1 and mtime=0.
REQ-037 Issue a write and a read at the same time to mtimecmp, held at reset value -> read returns all-ones; the next read returns the new value.
